// File: rtl/storage_bank_arbiter_if.sv
// Write/read bus between the requesters and storage_bank_arbiter.
//   master : requester side; drives req, wr_addr, wr_data and rd_addr,
//            and observes gnt, gnt_id, busy, wr_cnt and rd_data.
//   slave  : arbiter side (mirror of master).
// Parameters must match those of the storage_bank_arbiter instance.
interface storage_bank_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 2,
  parameter int unsigned CW   = 8
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] wr_addr;
  logic [NREQ*DW-1:0] wr_data;
  logic [NREQ-1:0]    gnt;
  logic [IDW-1:0]     gnt_id;
  logic               busy;
  logic [CW-1:0]      wr_cnt;
  logic [AW-1:0]      rd_addr;
  logic [DW-1:0]      rd_data;

  modport master (
    output req, wr_addr, wr_data, rd_addr,
    input  gnt, gnt_id, busy, wr_cnt, rd_data
  );

  modport slave (
    input  req, wr_addr, wr_data, rd_addr,
    output gnt, gnt_id, busy, wr_cnt, rd_data
  );
endinterface

// File: rtl/storage_bank_arbiter.sv
// Round-robin arbiter owning the only write path into a 2**AW x DW register
// bank shared by NREQ requesters. At most one write per clock edge; the
// winner gets a registered one-hot grant for the following cycle.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset (clears bank and all outputs)
//   bus     : slave side of storage_bank_arbiter_if
//             req/wr_addr/wr_data : per-requester write requests (flattened)
//             gnt/gnt_id/busy     : registered grant, last winner, write flag
//             wr_cnt              : registered write count, wraps silently
//             rd_addr/rd_data     : combinational read port
module storage_bank_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 2,
  parameter int unsigned CW   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  storage_bank_arbiter_if.slave bus
);
  localparam int unsigned IDW   = $clog2(NREQ);
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0]   bank [DEPTH];
  logic [NREQ-1:0] gnt_q;
  logic [IDW-1:0]  gnt_id_q;
  logic            busy_q;
  logic [CW-1:0]   wr_cnt_q;
  logic [IDW-1:0]  ptr_q;

  logic [NREQ-1:0] elig;
  logic            found;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  idx;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [IDW-1:0]  ptr_nxt;

  // The lane granted last cycle sits out one arbitration so a req still
  // held during its grant cycle is not written twice.
  assign elig = bus.req & ~gnt_q;

  // Rotating priority search starting at ptr_q.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(ptr_q) + k) % NREQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Winner's address/data mux; other lanes never reach the bank.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_addr = bus.wr_addr[i*AW +: AW];
        sel_data = bus.wr_data[i*DW +: DW];
      end
    end
  end

  assign ptr_nxt = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);

  // Bank storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        bank[i] <= '0;
      end
    end else if (found) begin
      bank[sel_addr] <= sel_data;
    end
  end

  // Grant, pointer and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
      wr_cnt_q <= '0;
      ptr_q    <= '0;
    end else if (found) begin
      gnt_q    <= NREQ'(1) << win;
      gnt_id_q <= win;
      busy_q   <= 1'b1;
      wr_cnt_q <= wr_cnt_q + CW'(1);
      ptr_q    <= ptr_nxt;
    end else begin
      gnt_q  <= '0;
      busy_q <= 1'b0;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = busy_q;
  assign bus.wr_cnt  = wr_cnt_q;
  assign bus.rd_data = bank[bus.rd_addr];
endmodule

// File: tb/tb_storage_bank_arbiter.sv
// Directed bench for storage_bank_arbiter (NREQ=3, DW=8, AW=2, CW=8):
// a table of per-edge vectors plus hand sequences for counter wrap and
// mid-cycle reset.
module tb_storage_bank_arbiter;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  storage_bank_arbiter_if #(.NREQ(3), .DW(8), .AW(2), .CW(8)) bus ();

  storage_bank_arbiter #(.NREQ(3), .DW(8), .AW(2), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pre_rst;
    logic [2:0]  req;
    logic [5:0]  addr;
    logic [23:0] data;
    logic [1:0]  rd_addr;
    logic [2:0]  gnt;
    logic [1:0]  gid;
    logic        busy;
    logic [7:0]  cnt;
    logic [7:0]  rd;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(logic pr, logic [2:0] rq, logic [5:0] ad,
                              logic [23:0] dt, logic [1:0] ra, logic [2:0] g,
                              logic [1:0] gi, logic b, logic [7:0] c,
                              logic [7:0] r);
    vec_t v;
    v.pre_rst = pr; v.req = rq; v.addr = ad; v.data = dt; v.rd_addr = ra;
    v.gnt = g; v.gid = gi; v.busy = b; v.cnt = c; v.rd = r;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.req = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;

    // addr = {a2,a1,a0}, data = {d2,d1,d0}
    // All three requesting, lanes 0/1/2 -> addr 0/1/3, data 10/20/30.
    vecs[0]  = mk(0, 3'b111, 6'b11_01_00, 24'h302010, 2'd0, 3'b001, 2'd0, 1, 8'd1, 8'h10);
    vecs[1]  = mk(0, 3'b111, 6'b11_01_00, 24'h302010, 2'd1, 3'b010, 2'd1, 1, 8'd2, 8'h20);
    vecs[2]  = mk(0, 3'b111, 6'b11_01_00, 24'h302010, 2'd3, 3'b100, 2'd2, 1, 8'd3, 8'h30);
    vecs[3]  = mk(0, 3'b111, 6'b11_01_00, 24'h302010, 2'd0, 3'b001, 2'd0, 1, 8'd4, 8'h10);
    vecs[4]  = mk(0, 3'b111, 6'b11_01_00, 24'h302010, 2'd1, 3'b010, 2'd1, 1, 8'd5, 8'h20);
    vecs[5]  = mk(0, 3'b111, 6'b11_01_00, 24'h302010, 2'd3, 3'b100, 2'd2, 1, 8'd6, 8'h30);
    vecs[6]  = mk(0, 3'b000, 6'b11_01_00, 24'h302010, 2'd2, 3'b000, 2'd2, 0, 8'd6, 8'h00);
    // Single requester 1 -> addr 2 = A5; idle lanes carry junk that must not land.
    vecs[7]  = mk(0, 3'b010, 6'b11_10_11, 24'hEEA5FF, 2'd2, 3'b010, 2'd1, 1, 8'd7, 8'hA5);
    vecs[8]  = mk(0, 3'b010, 6'b11_10_11, 24'hEEA5FF, 2'd3, 3'b000, 2'd1, 0, 8'd7, 8'h30);
    vecs[9]  = mk(0, 3'b000, 6'b11_10_11, 24'hEEA5FF, 2'd2, 3'b000, 2'd1, 0, 8'd7, 8'hA5);
    // ptr=2 now: req 0 and 1 -> 0 wins by wrap-around, then 1.
    vecs[10] = mk(0, 3'b011, 6'b00_01_00, 24'h006B5A, 2'd0, 3'b001, 2'd0, 1, 8'd8, 8'h5A);
    vecs[11] = mk(0, 3'b010, 6'b00_01_00, 24'h006B5A, 2'd1, 3'b010, 2'd1, 1, 8'd9, 8'h6B);
    vecs[12] = mk(0, 3'b000, 6'b00_01_00, 24'h006B5A, 2'd1, 3'b000, 2'd1, 0, 8'd9, 8'h6B);
    // Reset, then requesters 0 and 2 both hit addr 3: 11 first, 22 last.
    vecs[13] = mk(1, 3'b101, 6'b11_00_11, 24'h220011, 2'd3, 3'b001, 2'd0, 1, 8'd1, 8'h11);
    vecs[14] = mk(0, 3'b100, 6'b11_00_11, 24'h220011, 2'd3, 3'b100, 2'd2, 1, 8'd2, 8'h22);
    vecs[15] = mk(0, 3'b000, 6'b11_00_11, 24'h220011, 2'd3, 3'b000, 2'd2, 0, 8'd2, 8'h22);

    // Reset state and read sweep.
    #12;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cnt", 32'(bus.wr_cnt), 32'd0);
    chk("rst_gid", 32'(bus.gnt_id), 32'd0);
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr = 2'(a);
      #1;
      chk($sformatf("rst_rd%0d", a), 32'(bus.rd_data), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].pre_rst) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      bus.req     = vecs[i].req;
      bus.wr_addr = vecs[i].addr;
      bus.wr_data = vecs[i].data;
      bus.rd_addr = vecs[i].rd_addr;
      step();
      chk($sformatf("v%0d_gnt", i), 32'(bus.gnt), 32'(vecs[i].gnt));
      chk($sformatf("v%0d_gid", i), 32'(bus.gnt_id), 32'(vecs[i].gid));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d_cnt", i), 32'(bus.wr_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_rd", i), 32'(bus.rd_data), 32'(vecs[i].rd));
    end

    // Counter wrap: two requesters give one write per edge; 2 + 253 = 255.
    bus.req     = 3'b011;
    bus.wr_addr = 6'b00_10_00;
    bus.wr_data = 24'h006655;
    bus.rd_addr = 2'd2;
    for (int i = 0; i < 253; i++) begin
      step();
      chk("wrap_busy", 32'(bus.busy), 32'd1);
    end
    chk("cnt_255", 32'(bus.wr_cnt), 32'd255);
    chk("pre_wrap_gnt", 32'(bus.gnt), 32'b001);
    chk("pre_wrap_rd", 32'(bus.rd_data), 32'h66);
    bus.wr_data = 24'h007755;
    step();
    chk("wrap_cnt", 32'(bus.wr_cnt), 32'd0);
    chk("wrap_gnt", 32'(bus.gnt), 32'b010);
    chk("wrap_gid", 32'(bus.gnt_id), 32'd1);
    chk("wrap_rd", 32'(bus.rd_data), 32'h77);
    step();
    chk("post_wrap_cnt", 32'(bus.wr_cnt), 32'd1);
    chk("post_wrap_gnt", 32'(bus.gnt), 32'b001);

    // Mid-cycle reset clears everything before the next edge; ptr restarts at 0.
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_cnt", 32'(bus.wr_cnt), 32'd0);
    chk("mid_rst_rd", 32'(bus.rd_data), 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    chk("after_rst_gnt", 32'(bus.gnt), 32'b001);
    chk("after_rst_cnt", 32'(bus.wr_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
